// File: rtl/kpd_pkg.sv
// kpd_pkg: key map, FSM encoding and default timing shared by the keypad emulator and decoder
package kpd_pkg;

    localparam int HOLD_CYC_DEF = 100000;
    localparam int GAP_CYC_DEF  = 50000;

    typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] c;
    } key_pos_t;

    // Row index counts top->bottom, column index counts left->right
    function automatic key_pos_t key_pos(input logic [3:0] code);
        case (code)
            4'h1: return '{r: 2'd0, c: 2'd0};
            4'h2: return '{r: 2'd0, c: 2'd1};
            4'h3: return '{r: 2'd0, c: 2'd2};
            4'hA: return '{r: 2'd0, c: 2'd3};
            4'h4: return '{r: 2'd1, c: 2'd0};
            4'h5: return '{r: 2'd1, c: 2'd1};
            4'h6: return '{r: 2'd1, c: 2'd2};
            4'hB: return '{r: 2'd1, c: 2'd3};
            4'h7: return '{r: 2'd2, c: 2'd0};
            4'h8: return '{r: 2'd2, c: 2'd1};
            4'h9: return '{r: 2'd2, c: 2'd2};
            4'hC: return '{r: 2'd2, c: 2'd3};
            4'h0: return '{r: 2'd3, c: 2'd0};
            4'hF: return '{r: 2'd3, c: 2'd1};
            4'hE: return '{r: 2'd3, c: 2'd2};
            default: return '{r: 2'd3, c: 2'd3};
        endcase
    endfunction

endpackage

// File: rtl/kpd_fifo.sv
// kpd_fifo: synchronous FIFO with full/empty flags and occupancy count
module kpd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage has no reset; only pointers and count define validity
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: replays queued key codes as timed presses on an active-low 4x4 scan matrix
module keypad_emulator
    import kpd_pkg::*;
#(
    parameter int HOLD_CYC   = HOLD_CYC_DEF,
    parameter int GAP_CYC    = GAP_CYC_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          key_valid,
    input  logic [3:0]                    key_code,
    output logic                          key_ready,
    input  logic [3:0]                    col,
    output logic [3:0]                    row,
    output logic                          pressed,
    output logic [3:0]                    key_active,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2((HOLD_CYC > GAP_CYC ? HOLD_CYC : GAP_CYC) + 1);

    state_t     state;
    logic [CW-1:0] cnt;
    logic       full;
    logic       empty;
    logic       pop;
    logic [3:0] fifo_dout;
    key_pos_t   pos;

    assign key_ready = ~full;
    assign pop       = state == IDLE && !empty;
    assign busy      = state != IDLE || !empty;
    assign pos       = key_pos(key_active);

    kpd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(4)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (key_valid && key_ready),
        .pop   (pop),
        .din   (key_code),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // Press/release sequencer; one shared down-counter times both phases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            pressed    <= 1'b0;
            key_active <= 4'h0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    state      <= PRESS;
                    cnt        <= CW'(HOLD_CYC - 1);
                    pressed    <= 1'b1;
                    key_active <= fifo_dout;
                end
                PRESS: if (cnt == '0) begin
                    state      <= RELEASE;
                    cnt        <= CW'(GAP_CYC - 1);
                    pressed    <= 1'b0;
                    key_active <= 4'h0;
                end else cnt <= cnt - 1'b1;
                RELEASE: if (cnt == '0) state <= IDLE;
                    else cnt <= cnt - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

    // Row answer: pull the held key's row low when its column is strobed (3-x == ~x on 2 bits)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) row <= 4'hF;
        else row <= (pressed && !col[~pos.c]) ? ~(4'b1000 >> pos.r) : 4'hF;
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed and random checks of keypad_emulator against a schedule-based model
module tb_keypad_emulator;

    localparam int HOLD  = 8;
    localparam int GAP   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [3:0] col = 4'hF;
    logic       key_ready;
    logic [3:0] row;
    logic       pressed;
    logic [3:0] key_active;
    logic       busy;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;

    keypad_emulator #(.HOLD_CYC(HOLD), .GAP_CYC(GAP), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .col        (col),
        .row        (row),
        .pressed    (pressed),
        .key_active (key_active),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Model: pending-key queue plus the edge index p of the last pop; a key is held for
    // edges p..p+HOLD-1, released until p+HOLD+GAP-1, and the next pop may occur at p+HOLD+GAP+1
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}};

    int         cyc = 0;
    int         p = -1000;
    int         free_edge = 0;
    logic [3:0] mkey = 4'h0;
    logic [3:0] m_row = 4'hF;
    logic [3:0] q[$];

    function automatic logic [3:0] expect_row(input logic [3:0] k, input logic [3:0] c_lines);
        logic [3:0] r = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (KEYMAP[rr][cc] == k && c_lines[3-cc] == 1'b0) r[3-rr] = 1'b0;
        return r;
    endfunction

    function automatic logic held_at(input int e);
        return e >= p && e - p < HOLD;
    endfunction

    function automatic logic m_pressed();
        return held_at(cyc);
    endfunction

    function automatic logic [3:0] m_kact();
        return held_at(cyc) ? mkey : 4'h0;
    endfunction

    function automatic logic m_busy();
        return q.size() > 0 || (cyc >= p && cyc - p < HOLD + GAP);
    endfunction

    function automatic logic m_ready();
        return q.size() < DEPTH;
    endfunction

    task automatic model_reset();
        q.delete();
        p = -1000;
        free_edge = 0;
        mkey = 4'h0;
        m_row = 4'hF;
    endtask

    task automatic step();
        logic rdy;
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            cyc++;
            m_row = held_at(cyc - 1) ? expect_row(mkey, col) : 4'hF;
            rdy = m_ready();
            if (q.size() > 0 && cyc >= free_edge) begin
                mkey = q.pop_front();
                p = cyc;
                free_edge = cyc + HOLD + GAP + 1;
            end
            if (key_valid && rdy) q.push_back(key_code);
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200 && busy; i++) step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s idle timeout: busy=%b want 0", name, busy); end
    endtask

    task automatic wait_pressed(input string name);
        for (int i = 0; i < 60 && !pressed; i++) step();
        checks++;
        if (pressed !== 1'b1) begin errors++; $display("FAIL %s press timeout: pressed=%b want 1", name, pressed); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        step();
        step();
        checks++;
        if ({row, pressed, key_active, busy, key_ready, fifo_count} !== {4'hF, 1'b0, 4'h0, 1'b0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL reset: row=%h pressed=%b kact=%h busy=%b ready=%b cnt=%0d want F 0 0 0 1 0",
                     row, pressed, key_active, busy, key_ready, fifo_count);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_press();
        int pc = 0;
        int rc = 0;
        wait_idle("single");
        col = 4'b1011;
        key_valid = 1'b1;
        key_code = 4'h5;
        step();
        key_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (row !== m_row || pressed !== m_pressed() || key_active !== m_kact()) begin
                errors++;
                $display("FAIL single cyc%0d: row=%b pressed=%b kact=%h want %b %b %h",
                         i, row, pressed, key_active, m_row, m_pressed(), m_kact());
            end
            if (pressed) pc++;
            if (row == 4'b1011) rc++;
        end
        checks++;
        if (pc != HOLD || rc != HOLD) begin
            errors++;
            $display("FAIL single lengths: pressed=%0d row_low=%0d want %0d", pc, rc, HOLD);
        end
        checks++;
        if (row !== 4'hF) begin errors++; $display("FAIL single release: row=%b want 1111", row); end
    endtask

    task automatic test_col_walk();
        int lows = 0;
        wait_idle("walk");
        col = 4'hF;
        key_valid = 1'b1;
        key_code = 4'hD;
        step();
        key_valid = 1'b0;
        wait_pressed("walk");
        for (int i = 0; i < 8; i++) begin
            col = ~(4'b1000 >> (i % 4));
            step();
            checks++;
            if (row !== m_row || row[3:1] !== 3'b111) begin
                errors++;
                $display("FAIL walk step%0d: row=%b want %b", i, row, m_row);
            end
            if (row[0] == 1'b0) lows++;
        end
        checks++;
        if (lows != 2) begin errors++; $display("FAIL walk lows: got %0d want 2", lows); end
        col = 4'hF;
    endtask

    task automatic test_burst();
        logic [3:0] codes [5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4};
        logic [3:0] seen [$];
        int idx = 0;
        int gap = 0;
        logic prev = 1'b0;
        logic rdy;
        wait_idle("burst");
        col = 4'h0;
        for (int i = 0; i < 90; i++) begin
            key_valid = idx < 5;
            key_code = idx < 5 ? codes[idx] : 4'h0;
            rdy = m_ready();
            step();
            if (key_valid && rdy) idx++;
            checks++;
            if (key_ready !== m_ready() || fifo_count !== 3'(q.size()) || row !== m_row) begin
                errors++;
                $display("FAIL burst cyc%0d: ready=%b cnt=%0d row=%b want %b %0d %b",
                         i, key_ready, fifo_count, row, m_ready(), q.size(), m_row);
            end
            if (pressed && !prev) begin
                seen.push_back(key_active);
                if (seen.size() > 1) begin
                    checks++;
                    if (gap != GAP + 1) begin errors++; $display("FAIL burst gap: got %0d want %0d", gap, GAP + 1); end
                end
                gap = 0;
            end
            if (!pressed) gap++;
            prev = pressed;
        end
        key_valid = 1'b0;
        checks++;
        if (seen.size() != 5) begin
            errors++;
            $display("FAIL burst count: got %0d presses want 5", seen.size());
        end else
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (seen[k] !== codes[k]) begin
                    errors++;
                    $display("FAIL burst order[%0d]: got %h want %h", k, seen[k], codes[k]);
                end
            end
        col = 4'hF;
    endtask

    task automatic test_push_pop();
        wait_idle("pushpop");
        key_valid = 1'b1;
        key_code = 4'h0;
        step();
        checks++;
        if (fifo_count !== 3'd1) begin errors++; $display("FAIL pushpop first: cnt=%0d want 1", fifo_count); end
        key_code = 4'h7;
        step();
        key_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd1 || pressed !== 1'b1 || key_active !== 4'h0) begin
            errors++;
            $display("FAIL pushpop same: cnt=%0d pressed=%b kact=%h want 1 1 0", fifo_count, pressed, key_active);
        end
        for (int i = 0; i < 40 && !(pressed && key_active == 4'h7); i++) step();
        checks++;
        if (key_active !== 4'h7 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL pushpop second: kact=%h cnt=%0d want 7 0", key_active, fifo_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] codes [3] = '{4'h6, 4'hB, 4'hC};
        wait_idle("rstmid");
        col = 4'h0;
        for (int i = 0; i < 3; i++) begin
            key_valid = 1'b1;
            key_code = codes[i];
            step();
        end
        key_valid = 1'b0;
        step();
        checks++;
        if (fifo_count !== 3'd2 || row !== m_row || row !== 4'b1011) begin
            errors++;
            $display("FAIL rstmid before: cnt=%0d row=%b want 2 1011", fifo_count, row);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (row !== 4'hF || pressed !== 1'b0) begin
            errors++;
            $display("FAIL rstmid async: row=%b pressed=%b want 1111 0", row, pressed);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (fifo_count !== 3'd0 || busy !== 1'b0 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid after: cnt=%0d busy=%b ready=%b want 0 0 1", fifo_count, busy, key_ready);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (pressed !== 1'b0 || row !== 4'hF) begin
                errors++;
                $display("FAIL rstmid discard: pressed=%b row=%b want 0 1111", pressed, row);
            end
        end
        col = 4'hF;
    endtask

    task automatic test_all_cols();
        wait_idle("allcol");
        col = 4'hF;
        key_valid = 1'b1;
        key_code = 4'h9;
        step();
        key_valid = 1'b0;
        wait_pressed("allcol");
        col = 4'h0;
        step();
        checks++;
        if (row !== 4'b1101) begin errors++; $display("FAIL allcol low: row=%b want 1101", row); end
        col = 4'hF;
        step();
        checks++;
        if (row !== 4'hF) begin errors++; $display("FAIL allcol high: row=%b want 1111", row); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            key_valid = $urandom_range(0, 3) == 0;
            key_code = 4'($urandom);
            col = 4'($urandom);
            step();
            checks++;
            if (row !== m_row || pressed !== m_pressed() || key_active !== m_kact() ||
                busy !== m_busy() || key_ready !== m_ready() || fifo_count !== 3'(q.size())) begin
                errors++;
                $display("FAIL random cyc%0d: row=%b p=%b ka=%h busy=%b rdy=%b cnt=%0d want %b %b %h %b %b %0d",
                         i, row, pressed, key_active, busy, key_ready, fifo_count,
                         m_row, m_pressed(), m_kact(), m_busy(), m_ready(), q.size());
            end
        end
        key_valid = 1'b0;
        col = 4'hF;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_col_walk();
        test_burst();
        test_push_pop();
        test_reset_mid();
        test_all_cols();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
